// File: rtl/johnson_digit_display.sv
// Three-digit Johnson-code display sequencer: shows hundreds, tens, ones on a
// seven-segment port, then a blank gap, with load queuing and replay.
module johnson_digit_display #(
  parameter int pDWELL = 1000,
  parameter int pBLANK = 2000,
  parameter int pLZ    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_repeat,
  input  logic [4:0] i_100,
  input  logic [4:0] i_010,
  input  logic [4:0] i_001,
  output logic [7:0] o_led,
  output logic       o_busy,
  output logic       o_err
);

  localparam int cMAXC = (pDWELL > pBLANK) ? pDWELL : pBLANK;
  localparam int cCW   = $clog2(cMAXC + 1);
  localparam logic [cCW-1:0] cDWELL_LD = cCW'(pDWELL - 1);
  localparam logic [cCW-1:0] cBLANK_LD = cCW'(pBLANK - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHOW_H = 3'd1,
    ST_SHOW_T = 3'd2,
    ST_SHOW_O = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // Returns {valid, digit[3:0]} for a 5-bit Johnson code.
  function automatic logic [4:0] jdec(input logic [4:0] code);
    logic [4:0] d;
    case (code)
      5'b00000: d = 5'b1_0000;
      5'b00001: d = 5'b1_0001;
      5'b00011: d = 5'b1_0010;
      5'b00111: d = 5'b1_0011;
      5'b01111: d = 5'b1_0100;
      5'b11111: d = 5'b1_0101;
      5'b11110: d = 5'b1_0110;
      5'b11100: d = 5'b1_0111;
      5'b11000: d = 5'b1_1000;
      5'b10000: d = 5'b1_1001;
      default:  d = 5'b0_0000;
    endcase
    return d;
  endfunction

  function automatic logic [6:0] seg7(input logic [4:0] dec);
    logic [6:0] s;
    if (!dec[4]) begin
      s = 7'h79;
    end else begin
      case (dec[3:0])
        4'd0:    s = 7'h3F;
        4'd1:    s = 7'h06;
        4'd2:    s = 7'h5B;
        4'd3:    s = 7'h4F;
        4'd4:    s = 7'h66;
        4'd5:    s = 7'h6D;
        4'd6:    s = 7'h7D;
        4'd7:    s = 7'h07;
        4'd8:    s = 7'h7F;
        4'd9:    s = 7'h6F;
        default: s = 7'h79;
      endcase
    end
    return s;
  endfunction

  function automatic logic any_invalid(input logic [4:0] h, input logic [4:0] t,
                                       input logic [4:0] o);
    logic [4:0] dh, dt, dn;
    dh = jdec(h);
    dt = jdec(t);
    dn = jdec(o);
    return !(dh[4] && dt[4] && dn[4]);
  endfunction

  state_t         r_state;
  logic [cCW-1:0] r_cnt;
  logic [4:0]     r_h, r_t, r_o;
  logic [4:0]     r_ph, r_pt, r_po;
  logic           r_pend;
  logic [7:0]     r_led;
  logic           r_busy;
  logic           r_err;

  logic [6:0] w_h_seg, w_t_seg, w_o_seg;
  logic [7:0] w_led_nxt;
  logic       w_h_zero, w_t_zero, w_lz;
  logic       w_in_err, w_pend_err;

  assign w_lz       = (pLZ != 0);
  assign w_h_zero   = (r_h == 5'b00000);
  assign w_t_zero   = (r_t == 5'b00000);
  assign w_h_seg    = (w_lz && w_h_zero) ? 7'h00 : seg7(jdec(r_h));
  assign w_t_seg    = (w_lz && w_h_zero && w_t_zero) ? 7'h00 : seg7(jdec(r_t));
  assign w_o_seg    = seg7(jdec(r_o));
  assign w_in_err   = any_invalid(i_100, i_010, i_001);
  assign w_pend_err = any_invalid(r_ph, r_pt, r_po);

  // Pattern for the digit the current state selects; registered one cycle later.
  always_comb begin
    w_led_nxt = 8'h00;
    case (r_state)
      ST_SHOW_H: w_led_nxt = {1'b0, w_h_seg};
      ST_SHOW_T: w_led_nxt = {1'b0, w_t_seg};
      ST_SHOW_O: w_led_nxt = {1'b1, w_o_seg};
      default:   w_led_nxt = 8'h00;
    endcase
  end

  // Sequencer state, dwell counter, snapshot/pending registers and outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_h     <= 5'b00000;
      r_t     <= 5'b00000;
      r_o     <= 5'b00000;
      r_ph    <= 5'b00000;
      r_pt    <= 5'b00000;
      r_po    <= 5'b00000;
      r_pend  <= 1'b0;
      r_led   <= 8'h00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_led <= w_led_nxt;
      if (i_load && (r_state != ST_IDLE)) begin
        r_ph   <= i_100;
        r_pt   <= i_010;
        r_po   <= i_001;
        r_pend <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_h     <= i_100;
            r_t     <= i_010;
            r_o     <= i_001;
            r_err   <= w_in_err;
            r_state <= ST_SHOW_H;
            r_cnt   <= cDWELL_LD;
            r_busy  <= 1'b1;
          end
        end
        ST_SHOW_H, ST_SHOW_T, ST_SHOW_O: begin
          if (r_cnt == '0) begin
            r_state <= (r_state == ST_SHOW_H) ? ST_SHOW_T :
                       (r_state == ST_SHOW_T) ? ST_SHOW_O : ST_GAP;
            r_cnt   <= (r_state == ST_SHOW_O) ? cBLANK_LD : cDWELL_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_pend <= 1'b0;
            r_cnt  <= cDWELL_LD;
            // A load on this very cycle is the newest pending snapshot.
            if (i_load) begin
              r_h     <= i_100;
              r_t     <= i_010;
              r_o     <= i_001;
              r_err   <= w_in_err;
              r_state <= ST_SHOW_H;
            end else if (r_pend) begin
              r_h     <= r_ph;
              r_t     <= r_pt;
              r_o     <= r_po;
              r_err   <= w_pend_err;
              r_state <= ST_SHOW_H;
            end else if (i_repeat) begin
              r_state <= ST_SHOW_H;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;
  assign o_err  = r_err;

endmodule

// File: tb/tb_johnson_digit_display.sv
// Directed bench for johnson_digit_display with pDWELL=4, pBLANK=3; a second
// instance with leading-zero suppression disabled shares the same stimulus.
module tb_johnson_digit_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic       rpt;
  logic [4:0] d100, d010, d001;
  logic [7:0] led, led2;
  logic       busy, busy2, err, err2;

  int n_vec = 0;
  int n_err = 0;

  logic       mid_en = 1'b0;
  int         mid_at = 0;
  logic [4:0] mid_h, mid_t, mid_o;

  localparam logic [4:0] J0 = 5'b00000, J1 = 5'b00001, J2 = 5'b00011, J3 = 5'b00111,
                         J4 = 5'b01111, J5 = 5'b11111, J7 = 5'b11100, J8 = 5'b11000,
                         J9 = 5'b10000, JBAD = 5'b00101;

  always #5 clk = ~clk;

  johnson_digit_display #(.pDWELL(4), .pBLANK(3), .pLZ(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_repeat(rpt),
    .i_100(d100), .i_010(d010), .i_001(d001),
    .o_led(led), .o_busy(busy), .o_err(err)
  );

  johnson_digit_display #(.pDWELL(4), .pBLANK(3), .pLZ(0)) u_dut_nlz (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_repeat(rpt),
    .i_100(d100), .i_010(d010), .i_001(d001),
    .o_led(led2), .o_busy(busy2), .o_err(err2)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Returns at the negedge just after the acceptance edge.
  task automatic do_load(input logic [4:0] h, input logic [4:0] t, input logic [4:0] o);
    @(negedge clk);
    d100 = h; d010 = t; d001 = o; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Walks the 15 cycles after a frame's SHOW_H entry edge.
  task automatic check_frame(input string tag,
                             input logic [7:0] ph, input logic [7:0] pt, input logic [7:0] po,
                             input logic [7:0] qh, input logic [7:0] qt, input logic [7:0] qo,
                             input logic exp_err, input logic end_busy);
    logic [7:0] e1, e2;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i <= 4)       begin e1 = ph; e2 = qh; end
      else if (i <= 8)  begin e1 = pt; e2 = qt; end
      else if (i <= 12) begin e1 = po; e2 = qo; end
      else              begin e1 = 8'h00; e2 = 8'h00; end
      chk($sformatf("%s led c%0d", tag, i), led, e1);
      chk($sformatf("%s led_nlz c%0d", tag, i), led2, e2);
      if (i == 1 || i == 14) chk($sformatf("%s err c%0d", tag, i), {7'd0, err}, {7'd0, exp_err});
      if (i == 14) chk({tag, " busy_mid"}, {7'd0, busy}, 8'h01);
      if (i == 15) chk({tag, " busy_end"}, {7'd0, busy}, {7'd0, end_busy});
      if (load) load = 1'b0;
      if (mid_en && i == mid_at) begin
        d100 = mid_h; d010 = mid_t; d001 = mid_o; load = 1'b1;
        mid_en = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; rpt = 1'b0;
    d100 = J4; d010 = J0; d001 = J7;
    repeat (3) @(negedge clk);
    chk("rst led", led, 8'h00);
    chk("rst busy", {7'd0, busy}, 8'h00);
    chk("rst err", {7'd0, err}, 8'h00);
    rst_n = 1'b1; load = 1'b0;
    @(negedge clk);
    chk("rst load_ignored", {7'd0, busy}, 8'h00);

    // 4-0-7 basic frame
    do_load(J4, J0, J7);
    chk("basic accept busy", {7'd0, busy}, 8'h01);
    chk("basic accept led", led, 8'h00);
    check_frame("basic", 8'h66, 8'h3F, 8'h87, 8'h66, 8'h3F, 8'h87, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic idle led", led, 8'h00);

    // 0-0-5 leading zeros
    do_load(J0, J0, J5);
    check_frame("lz", 8'h00, 8'h00, 8'hED, 8'h3F, 8'h3F, 8'hED, 1'b0, 1'b0);

    // 3-E-1 invalid tens
    do_load(J3, JBAD, J1);
    chk("inv accept err", {7'd0, err}, 8'h01);
    check_frame("inv", 8'h4F, 8'h79, 8'h86, 8'h4F, 8'h79, 8'h86, 1'b1, 1'b0);
    @(negedge clk);
    chk("inv sticky err", {7'd0, err}, 8'h01);

    // 1-2-3 with 9-8-7 queued during SHOW_T
    mid_en = 1'b1; mid_at = 6; mid_h = J9; mid_t = J8; mid_o = J7;
    do_load(J1, J2, J3);
    chk("pend accept err_clr", {7'd0, err}, 8'h00);
    check_frame("f123", 8'h06, 8'h5B, 8'hCF, 8'h06, 8'h5B, 8'hCF, 1'b0, 1'b1);
    rpt = 1'b1;
    check_frame("f987", 8'h6F, 8'h7F, 8'h87, 8'h6F, 8'h7F, 8'h87, 1'b0, 1'b1);
    rpt = 1'b0;
    check_frame("rep987", 8'h6F, 8'h7F, 8'h87, 8'h6F, 8'h7F, 8'h87, 1'b0, 1'b0);

    // Reset during SHOW_O with a pending snapshot
    do_load(J4, J0, J7);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 2) begin
        d100 = J1; d010 = J2; d001 = J3; load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    chk("mid pre_rst led", led, 8'h87);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst led", led, 8'h00);
    chk("mid rst busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid pend_dropped busy", {7'd0, busy}, 8'h00);
    chk("mid pend_dropped led", led, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
